// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM encoding,
// access size masks, exception codes and the memory window.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic [7:0] SEL_B = 8'h01;
    localparam logic [7:0] SEL_H = 8'h03;
    localparam logic [7:0] SEL_W = 8'h0F;
    localparam logic [7:0] SEL_D = 8'hFF;

    localparam logic [3:0] LD_MISALIGN = 4'd4;
    localparam logic [3:0] LD_FAULT    = 4'd5;
    localparam logic [3:0] ST_MISALIGN = 4'd6;
    localparam logic [3:0] ST_FAULT    = 4'd7;

    localparam logic [63:0] DMEM_BASE       = 64'h0000_0000_8000_0000;
    localparam int unsigned DMEM_SIZE_BYTES = 16384;

    // Number of bytes covered by a size mask; 0 flags an illegal mask.
    function automatic int unsigned sel_bytes(input logic [7:0] sel);
        case (sel)
            SEL_B:   return 1;
            SEL_H:   return 2;
            SEL_W:   return 4;
            SEL_D:   return 8;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_rr_picker.sv
// Two-way request picker: combinational winner selection with a
// round-robin pointer that a fixed-priority build simply ignores.
module dmem_rr_picker #(
    parameter int PRIO_MODE = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic winner
);

    logic ptr;

    // ptr names the port preferred on the next tie; 0 after reset.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = (PRIO_MODE == 1) ? 1'b0 : ptr;
        end else if (req1) begin
            winner = 1'b1;
        end
        gnt0 = en && req0 && !winner;
        gnt1 = en && req1 && winner;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (gnt0) begin
            ptr <= 1'b1;
        end else if (gnt1) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the data memory: grant one request,
// run a single memory access cycle, then hold the response until consumed.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int PRIO_MODE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            p0_req,
    input  logic            p0_we,
    input  logic            p0_is_load,
    input  logic [7:0]      p0_word_sel,
    input  logic [2:0]      p0_func3,
    input  logic [XLEN-1:0] p0_addr,
    input  logic [XLEN-1:0] p0_wdata,
    output logic            p0_gnt,
    output logic            p0_rvalid,
    input  logic            p0_rready,
    input  logic            p1_req,
    input  logic            p1_we,
    input  logic            p1_is_load,
    input  logic [7:0]      p1_word_sel,
    input  logic [2:0]      p1_func3,
    input  logic [XLEN-1:0] p1_addr,
    input  logic [XLEN-1:0] p1_wdata,
    output logic            p1_gnt,
    output logic            p1_rvalid,
    input  logic            p1_rready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_exc,
    output logic [3:0]      rsp_exc_code,
    output logic [XLEN-1:0] rsp_exc_val,
    output logic            mem_we,
    output logic            mem_is_load,
    output logic [7:0]      mem_word_sel,
    output logic [2:0]      mem_func3,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_exc_en,
    input  logic [3:0]      mem_exc_code,
    input  logic [XLEN-1:0] mem_exc_val,
    output logic            busy
);

    arb_state_t      state;
    logic            owner;
    logic            winner;
    logic            grant;
    logic            access_valid;
    logic            owner_rready;
    logic            sel_we;
    logic            sel_is_load;
    logic [7:0]      sel_word_sel;
    logic [2:0]      sel_func3;
    logic [XLEN-1:0] sel_addr;
    logic [XLEN-1:0] sel_wdata;

    dmem_rr_picker #(
        .PRIO_MODE(PRIO_MODE)
    ) u_picker (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state == IDLE),
        .req0   (p0_req),
        .req1   (p1_req),
        .gnt0   (p0_gnt),
        .gnt1   (p1_gnt),
        .winner (winner)
    );

    assign sel_we       = winner ? p1_we       : p0_we;
    assign sel_is_load  = winner ? p1_is_load  : p0_is_load;
    assign sel_word_sel = winner ? p1_word_sel : p0_word_sel;
    assign sel_func3    = winner ? p1_func3    : p0_func3;
    assign sel_addr     = winner ? p1_addr     : p0_addr;
    assign sel_wdata    = winner ? p1_wdata    : p0_wdata;

    assign grant        = p0_gnt | p1_gnt;
    assign access_valid = mem_we | mem_is_load;
    assign owner_rready = owner ? p1_rready : p0_rready;
    assign busy         = (state != IDLE);

    // mem_we/mem_is_load double as the latched request type: they are high
    // only during ACCESS, while the address/data registers keep their values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= 1'b0;
            mem_we       <= 1'b0;
            mem_is_load  <= 1'b0;
            mem_word_sel <= '0;
            mem_func3    <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            rsp_rdata    <= '0;
            rsp_exc      <= 1'b0;
            rsp_exc_code <= '0;
            rsp_exc_val  <= '0;
            p0_rvalid    <= 1'b0;
            p1_rvalid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner        <= winner;
                        mem_we       <= sel_we;
                        mem_is_load  <= sel_is_load;
                        mem_word_sel <= sel_word_sel;
                        mem_func3    <= sel_func3;
                        mem_addr     <= sel_addr;
                        mem_wdata    <= sel_wdata;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we       <= 1'b0;
                    mem_is_load  <= 1'b0;
                    rsp_rdata    <= mem_is_load ? mem_rdata : '0;
                    rsp_exc      <= access_valid && mem_exc_en;
                    rsp_exc_code <= (access_valid && mem_exc_en) ? mem_exc_code : 4'd0;
                    rsp_exc_val  <= (access_valid && mem_exc_en) ? mem_exc_val : '0;
                    p0_rvalid    <= !owner;
                    p1_rvalid    <= owner;
                    state        <= RESP;
                end
                RESP: begin
                    if (owner_rready) begin
                        p0_rvalid <= 1'b0;
                        p1_rvalid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Structural invariants of the sequencer.
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(p0_gnt && p1_gnt));
    a_mem_strobe_access: assert property (@(posedge clk) disable iff (!rst_n)
        (mem_we || mem_is_load) |-> (state == ACCESS));
    a_rvalid_resp: assert property (@(posedge clk) disable iff (!rst_n)
        (p0_rvalid || p1_rvalid) |-> (state == RESP));
    a_rvalid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(p0_rvalid && p1_rvalid));
    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (state == RESP && !owner_rready) |=> ($stable(rsp_rdata) && $stable(rsp_exc)));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a byte-array memory model behind the
// round-robin instance and a tied-off fixed-priority instance.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        p0_req, p0_we, p0_is_load, p0_gnt, p0_rvalid, p0_rready;
    logic [7:0]  p0_word_sel;
    logic [2:0]  p0_func3;
    logic [63:0] p0_addr, p0_wdata;
    logic        p1_req, p1_we, p1_is_load, p1_gnt, p1_rvalid, p1_rready;
    logic [7:0]  p1_word_sel;
    logic [2:0]  p1_func3;
    logic [63:0] p1_addr, p1_wdata;
    logic [63:0] rsp_rdata, rsp_exc_val;
    logic        rsp_exc;
    logic [3:0]  rsp_exc_code;
    logic        mem_we, mem_is_load, busy;
    logic [7:0]  mem_word_sel;
    logic [2:0]  mem_func3;
    logic [63:0] mem_addr, mem_wdata;

    logic        f_p0_req, f_p0_gnt, f_p0_rvalid, f_p0_rready;
    logic        f_p1_req, f_p1_gnt, f_p1_rvalid, f_p1_rready;
    logic [63:0] f_rsp_rdata, f_rsp_exc_val, f_mem_addr, f_mem_wdata;
    logic        f_rsp_exc, f_mem_we, f_mem_is_load, f_busy;
    logic [3:0]  f_rsp_exc_code;
    logic [7:0]  f_mem_word_sel;
    logic [2:0]  f_mem_func3;

    int checks = 0;
    int failures = 0;
    int writes = 0;

    dmem_arbiter #(.XLEN(64), .PRIO_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_is_load(p0_is_load), .p0_word_sel(p0_word_sel),
        .p0_func3(p0_func3), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt),
        .p0_rvalid(p0_rvalid), .p0_rready(p0_rready),
        .p1_req(p1_req), .p1_we(p1_we), .p1_is_load(p1_is_load), .p1_word_sel(p1_word_sel),
        .p1_func3(p1_func3), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt),
        .p1_rvalid(p1_rvalid), .p1_rready(p1_rready),
        .rsp_rdata(rsp_rdata), .rsp_exc(rsp_exc), .rsp_exc_code(rsp_exc_code), .rsp_exc_val(rsp_exc_val),
        .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_word_sel(mem_word_sel), .mem_func3(mem_func3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(m_rdata), .mem_exc_en(m_exc),
        .mem_exc_code(m_code), .mem_exc_val(m_val), .busy(busy)
    );

    dmem_arbiter #(.XLEN(64), .PRIO_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_req(f_p0_req), .p0_we(1'b0), .p0_is_load(1'b1), .p0_word_sel(SEL_W),
        .p0_func3(3'd2), .p0_addr(64'h8000_0000), .p0_wdata(64'h0), .p0_gnt(f_p0_gnt),
        .p0_rvalid(f_p0_rvalid), .p0_rready(f_p0_rready),
        .p1_req(f_p1_req), .p1_we(1'b0), .p1_is_load(1'b1), .p1_word_sel(SEL_W),
        .p1_func3(3'd2), .p1_addr(64'h8000_0000), .p1_wdata(64'h0), .p1_gnt(f_p1_gnt),
        .p1_rvalid(f_p1_rvalid), .p1_rready(f_p1_rready),
        .rsp_rdata(f_rsp_rdata), .rsp_exc(f_rsp_exc), .rsp_exc_code(f_rsp_exc_code), .rsp_exc_val(f_rsp_exc_val),
        .mem_we(f_mem_we), .mem_is_load(f_mem_is_load), .mem_word_sel(f_mem_word_sel), .mem_func3(f_mem_func3),
        .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_rdata(64'h0), .mem_exc_en(1'b0),
        .mem_exc_code(4'd0), .mem_exc_val(64'h0), .busy(f_busy)
    );

    // Memory model: combinational read/exception, write at the end of ACCESS.
    logic [7:0]  mem_arr [0:16383];
    logic [63:0] m_rdata, m_val, m_raw, m_off, m_nb;
    logic        m_exc, m_inr, m_mis;
    logic [3:0]  m_code;

    always_comb begin
        m_rdata = '0; m_val = '0; m_raw = '0; m_exc = 1'b0; m_code = 4'd0;
        m_nb  = 64'(sel_bytes(mem_word_sel));
        m_off = mem_addr - DMEM_BASE;
        m_inr = (mem_addr >= DMEM_BASE) && ((m_off + m_nb) <= 64'(DMEM_SIZE_BYTES));
        m_mis = (m_nb == 0) || ((mem_addr & (m_nb - 64'd1)) != 64'd0);
        if (mem_we || mem_is_load) begin
            if (m_mis) begin
                m_exc = 1'b1; m_code = mem_is_load ? LD_MISALIGN : ST_MISALIGN; m_val = mem_addr;
            end else if (!m_inr) begin
                m_exc = 1'b1; m_code = mem_is_load ? LD_FAULT : ST_FAULT; m_val = mem_addr;
            end
        end
        if (mem_is_load && !m_exc) begin
            for (int i = 0; i < 8; i++) begin
                if (64'(i) < m_nb) m_raw[8*i +: 8] = mem_arr[int'(m_off[13:0]) + i];
            end
            case (mem_func3)
                3'd0: m_rdata = {{56{m_raw[7]}}, m_raw[7:0]};
                3'd1: m_rdata = {{48{m_raw[15]}}, m_raw[15:0]};
                3'd2: m_rdata = {{32{m_raw[31]}}, m_raw[31:0]};
                3'd4: m_rdata = {56'd0, m_raw[7:0]};
                3'd5: m_rdata = {48'd0, m_raw[15:0]};
                3'd6: m_rdata = {32'd0, m_raw[31:0]};
                default: m_rdata = m_raw;
            endcase
        end
    end

    always @(posedge clk) begin
        if (mem_we && !m_exc) begin
            for (int i = 0; i < 8; i++) begin
                if (64'(i) < m_nb) mem_arr[int'(m_off[13:0]) + i] <= mem_wdata[8*i +: 8];
            end
            writes <= writes + 1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_port(input int port, input logic req, input logic we, input logic ld,
                              input logic [7:0] sel, input logic [2:0] f3,
                              input logic [63:0] addr, input logic [63:0] wdata);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_is_load = ld; p0_word_sel = sel;
            p0_func3 = f3; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_is_load = ld; p1_word_sel = sel;
            p1_func3 = f3; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_port(0, 0, 0, 0, 8'h0, 3'd0, 64'h0, 64'h0);
        drive_port(1, 0, 0, 0, 8'h0, 3'd0, 64'h0, 64'h0);
        p0_rready = 1'b0; p1_rready = 1'b0;
        f_p0_req = 1'b0; f_p1_req = 1'b0; f_p0_rready = 1'b0; f_p1_rready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one transaction on a port; reports grant wait, rvalid latency
    // (cycles after grant), the response and rvalid one cycle after the handshake.
    task automatic run_txn(input int port, input logic we, input logic ld, input logic [7:0] sel,
                           input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wdata,
                           output int gwait, output int rlat, output logic [63:0] rdata,
                           output logic exc, output logic [3:0] code, output logic [63:0] val,
                           output logic rv_after);
        @(negedge clk);
        drive_port(port, 1, we, ld, sel, f3, addr, wdata);
        if (port == 0) p0_rready = 1'b1; else p1_rready = 1'b1;
        #1;
        gwait = 0;
        while (!(port == 0 ? p0_gnt : p1_gnt) && gwait < 20) begin
            @(negedge clk); #1; gwait++;
        end
        @(negedge clk);
        drive_port(port, 0, 0, 0, 8'h0, 3'd0, 64'h0, 64'h0);
        #1;
        rlat = 1;
        while (!(port == 0 ? p0_rvalid : p1_rvalid) && rlat < 20) begin
            @(negedge clk); #1; rlat++;
        end
        rdata = rsp_rdata; exc = rsp_exc; code = rsp_exc_code; val = rsp_exc_val;
        @(negedge clk); #1;
        rv_after = (port == 0) ? p0_rvalid : p1_rvalid;
        p0_rready = 1'b0; p1_rready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_port(0, 0, 0, 0, 8'h0, 3'd0, 64'h0, 64'h0);
        drive_port(1, 0, 0, 0, 8'h0, 3'd0, 64'h0, 64'h0);
        p0_rready = 1'b0; p1_rready = 1'b0;
        f_p0_req = 1'b0; f_p1_req = 1'b0; f_p0_rready = 1'b0; f_p1_rready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin failures++; $display("[TB] FAIL reset_rvalid got=%b%b exp=00", p0_rvalid, p1_rvalid); end
        checks++; if (mem_addr !== 64'h0) begin failures++; $display("[TB] FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (rsp_rdata !== 64'h0) begin failures++; $display("[TB] FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if ({p0_gnt, p1_gnt} !== 2'b00) begin failures++; $display("[TB] FAIL idle_gnt got=%b%b exp=00", p0_gnt, p1_gnt); end
    endtask

    task automatic test_store_load();
        int gw, rl; logic [63:0] rd, vl; logic ex, rva; logic [3:0] cd;
        run_txn(0, 1, 0, SEL_D, 3'd3, 64'h8000_0010, 64'h1122334455667788, gw, rl, rd, ex, cd, vl, rva);
        checks++; if (gw !== 0) begin failures++; $display("[TB] FAIL sd_gnt_wait got=%0d exp=0", gw); end
        checks++; if (rl !== 2) begin failures++; $display("[TB] FAIL sd_rvalid_lat got=%0d exp=2", rl); end
        checks++; if (rd !== 64'h0) begin failures++; $display("[TB] FAIL sd_rdata got=%h exp=0", rd); end
        checks++; if (ex !== 1'b0) begin failures++; $display("[TB] FAIL sd_exc got=%b exp=0", ex); end
        checks++; if (rva !== 1'b0) begin failures++; $display("[TB] FAIL sd_rvalid_drop got=%b exp=0", rva); end
        run_txn(0, 0, 1, SEL_D, 3'd3, 64'h8000_0010, 64'h0, gw, rl, rd, ex, cd, vl, rva);
        checks++; if (gw !== 0) begin failures++; $display("[TB] FAIL ld_gnt_wait got=%0d exp=0", gw); end
        checks++; if (rl !== 2) begin failures++; $display("[TB] FAIL ld_rvalid_lat got=%0d exp=2", rl); end
        checks++; if (rd !== 64'h1122334455667788) begin failures++; $display("[TB] FAIL ld_rdata got=%h exp=1122334455667788", rd); end
        checks++; if (ex !== 1'b0) begin failures++; $display("[TB] FAIL ld_exc got=%b exp=0", ex); end
    endtask

    task automatic test_round_robin();
        int ng, rv0, rv1, bad;
        int gcyc [4];
        logic [3:0] seq;
        apply_reset();
        ng = 0; rv0 = 0; rv1 = 0; bad = 0; seq = 4'b0;
        gcyc = '{default: 0};
        @(negedge clk);
        drive_port(0, 1, 0, 1, SEL_W, 3'd2, 64'h8000_0000, 64'h0);
        drive_port(1, 1, 0, 1, SEL_W, 3'd2, 64'h8000_0000, 64'h0);
        p0_rready = 1'b1; p1_rready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (p0_gnt && p1_gnt) bad++;
            if (ng < 4 && p0_gnt) begin seq[ng] = 1'b0; gcyc[ng] = c; ng++; end
            else if (ng < 4 && p1_gnt) begin seq[ng] = 1'b1; gcyc[ng] = c; ng++; end
            if (p0_rvalid) begin rv0++; if (ng == 0 || seq[ng-1] !== 1'b0) bad++; end
            if (p1_rvalid) begin rv1++; if (ng == 0 || seq[ng-1] !== 1'b1) bad++; end
            @(negedge clk);
            if (ng == 4) begin
                drive_port(0, 0, 0, 0, 8'h0, 3'd0, 64'h0, 64'h0);
                drive_port(1, 0, 0, 0, 8'h0, 3'd0, 64'h0, 64'h0);
            end
        end
        p0_rready = 1'b0; p1_rready = 1'b0;
        checks++; if (ng !== 4) begin failures++; $display("[TB] FAIL rr_grant_count got=%0d exp=4", ng); end
        checks++; if (seq !== 4'b1010) begin failures++; $display("[TB] FAIL rr_order got=%b exp=1010 (bit0 first)", seq); end
        checks++; if (gcyc[1] - gcyc[0] !== 3) begin failures++; $display("[TB] FAIL rr_back_to_back got=%0d exp=3", gcyc[1] - gcyc[0]); end
        checks++; if (rv0 !== 2 || rv1 !== 2) begin failures++; $display("[TB] FAIL rr_rvalid_counts got=%0d/%0d exp=2/2", rv0, rv1); end
        checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL rr_rvalid_owner got=%0d exp=0", bad); end
    endtask

    task automatic test_fixed_priority();
        int g0, g1, g1_early, p1cyc;
        logic released;
        g0 = 0; g1 = 0; g1_early = 0; p1cyc = -1; released = 1'b0;
        @(negedge clk);
        f_p0_req = 1'b1; f_p1_req = 1'b1; f_p0_rready = 1'b1; f_p1_rready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (f_p0_gnt) g0++;
            if (f_p1_gnt) begin g1++; if (!released) g1_early++; if (p1cyc < 0) p1cyc = c; end
            @(negedge clk);
            if (g0 >= 3 && !released) begin f_p0_req = 1'b0; released = 1'b1; end
            if (g1 > 0) f_p1_req = 1'b0;
        end
        f_p0_rready = 1'b0; f_p1_rready = 1'b0;
        checks++; if (g0 !== 3) begin failures++; $display("[TB] FAIL fp_p0_grants got=%0d exp=3", g0); end
        checks++; if (g1_early !== 0) begin failures++; $display("[TB] FAIL fp_p1_while_p0 got=%0d exp=0", g1_early); end
        checks++; if (p1cyc !== 9) begin failures++; $display("[TB] FAIL fp_p1_grant_cycle got=%0d exp=9", p1cyc); end
    endtask

    task automatic test_exceptions();
        int gw, rl, w0; logic [63:0] rd, vl; logic ex, rva; logic [3:0] cd;
        run_txn(1, 0, 1, SEL_W, 3'd2, 64'h8000_0002, 64'h0, gw, rl, rd, ex, cd, vl, rva);
        checks++; if (ex !== 1'b1) begin failures++; $display("[TB] FAIL lw_mis_exc got=%b exp=1", ex); end
        checks++; if (cd !== 4'd4) begin failures++; $display("[TB] FAIL lw_mis_code got=%0d exp=4", cd); end
        checks++; if (vl !== 64'h8000_0002) begin failures++; $display("[TB] FAIL lw_mis_val got=%h exp=80000002", vl); end
        w0 = writes;
        run_txn(1, 1, 0, SEL_W, 3'd2, 64'h7FFF_FFF0, 64'hCAFE_F00D, gw, rl, rd, ex, cd, vl, rva);
        checks++; if (ex !== 1'b1) begin failures++; $display("[TB] FAIL sw_fault_exc got=%b exp=1", ex); end
        checks++; if (cd !== 4'd7) begin failures++; $display("[TB] FAIL sw_fault_code got=%0d exp=7", cd); end
        checks++; if (vl !== 64'h7FFF_FFF0) begin failures++; $display("[TB] FAIL sw_fault_val got=%h exp=7ffffff0", vl); end
        checks++; if (writes !== w0) begin failures++; $display("[TB] FAIL sw_fault_writes got=%0d exp=%0d", writes, w0); end
    endtask

    task automatic test_load_hold();
        int gw, rl, n, unstable, p1seen; logic [63:0] rd, vl, held; logic ex, rva; logic [3:0] cd;
        run_txn(0, 1, 0, SEL_B, 3'd0, 64'h8000_0020, 64'h80, gw, rl, rd, ex, cd, vl, rva);
        checks++; if (ex !== 1'b0) begin failures++; $display("[TB] FAIL sb_exc got=%b exp=0", ex); end
        @(negedge clk);
        drive_port(0, 1, 0, 1, SEL_B, 3'd0, 64'h8000_0020, 64'h0);
        p0_rready = 1'b0;
        #1;
        n = 0;
        while (!p0_gnt && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        drive_port(0, 0, 0, 0, 8'h0, 3'd0, 64'h0, 64'h0);
        #1;
        n = 1;
        while (!p0_rvalid && n < 20) begin @(negedge clk); #1; n++; end
        checks++; if (n !== 2) begin failures++; $display("[TB] FAIL lb_rvalid_lat got=%0d exp=2", n); end
        checks++; if (rsp_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin failures++; $display("[TB] FAIL lb_sext got=%h exp=ffffffffffffff80", rsp_rdata); end
        held = rsp_rdata;
        unstable = 0; p1seen = 0;
        drive_port(1, 1, 0, 1, SEL_W, 3'd2, 64'h8000_0000, 64'h0);
        p1_rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (!p0_rvalid || rsp_rdata !== held || rsp_exc !== 1'b0) unstable++;
            if (p1_gnt || p1_rvalid) p1seen++;
            @(negedge clk);
        end
        checks++; if (unstable !== 0) begin failures++; $display("[TB] FAIL hold_stable got=%0d exp=0", unstable); end
        checks++; if (p1seen !== 0) begin failures++; $display("[TB] FAIL hold_p1_blocked got=%0d exp=0", p1seen); end
        drive_port(1, 0, 0, 0, 8'h0, 3'd0, 64'h0, 64'h0);
        p0_rready = 1'b1;
        @(negedge clk); #1;
        checks++; if (p0_rvalid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL hold_release got=%b%b exp=00", p0_rvalid, busy); end
        p0_rready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int gw, rl, w0; logic [63:0] rd, vl; logic ex, rva; logic [3:0] cd;
        w0 = writes;
        @(negedge clk);
        drive_port(0, 1, 1, 0, SEL_D, 3'd3, 64'h8000_0010, 64'hDEADBEEF0BADF00D);
        #1;
        checks++; if (p0_gnt !== 1'b1) begin failures++; $display("[TB] FAIL rst_sd_gnt got=%b exp=1", p0_gnt); end
        @(posedge clk); #1;
        checks++; if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL rst_access_we got=%b exp=1", mem_we); end
        rst_n = 1'b0;
        drive_port(0, 0, 0, 0, 8'h0, 3'd0, 64'h0, 64'h0);
        #1;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_mem_we got=%b exp=0", mem_we); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (p0_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rst_rvalid got=%b exp=0", p0_rvalid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++; if (writes !== w0) begin failures++; $display("[TB] FAIL rst_no_write got=%0d exp=%0d", writes, w0); end
        run_txn(0, 0, 1, SEL_D, 3'd3, 64'h8000_0010, 64'h0, gw, rl, rd, ex, cd, vl, rva);
        checks++; if (rd !== 64'h1122334455667788) begin failures++; $display("[TB] FAIL rst_old_value got=%h exp=1122334455667788", rd); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_round_robin();
        test_fixed_priority();
        test_exceptions();
        test_load_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the byte-addressable data memory (base 0x8000_0000, 16 KB).
- Port 0 is the core load/store unit; port 1 is the debug/DMA loader.
- Captures one request at a time and drives the memory for exactly one access cycle. Returns read data or the memory's exception to the owning port through a valid/ready response.

Parameters:
- XLEN, 64, address and data width.
- PRIO_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 0 always wins.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- p0_req, p1_req  in  1  request valid.
- p0_we, p1_we  in  1  store.
- p0_is_load, p1_is_load  in  1  load.
- p0_word_sel, p1_word_sel  in  8  size mask: 0x01, 0x03, 0x0F or 0xFF.
- p0_func3, p1_func3  in  3  load extension select.
- p0_addr, p1_addr  in  XLEN  effective address.
- p0_wdata, p1_wdata  in  XLEN  store data.
- p0_gnt, p1_gnt  out  1  request accepted this cycle.
- p0_rvalid, p1_rvalid  out  1  response valid.
- p0_rready, p1_rready  in  1  response consumed.
- rsp_rdata  out  XLEN  load result; shared by both ports.
- rsp_exc  out  1  access raised an exception.
- rsp_exc_code  out  4  4, 5, 6 or 7.
- rsp_exc_val  out  XLEN  faulting address.
- mem_we  out  1  to memory write enable.
- mem_is_load  out  1  to memory load strobe.
- mem_word_sel  out  8  to memory size select.
- mem_func3  out  3  to memory.
- mem_addr  out  XLEN  to memory.
- mem_wdata  out  XLEN  to memory.
- mem_rdata  in  XLEN  from memory, combinational read.
- mem_exc_en  in  1  from memory.
- mem_exc_code  in  4  from memory.
- mem_exc_val  in  XLEN  from memory.
- busy  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset value of every output and register is 0; the round-robin pointer resets to port 0 (port 0 preferred).
- IDLE:
  - A port is eligible when its req is 1.
  - Winner: only eligible port; if both, PRIO_MODE=1 → port 0, PRIO_MODE=0 → port indicated by the pointer.
  - gnt is combinational, asserted to the winner only in the same cycle.
  - On that edge: latch the winner's we, is_load, word_sel, func3, addr, wdata and owner id; go to ACCESS.
  - Pointer moves to the other port after every grant; it is ignored when PRIO_MODE=1.
  - A request with we=0 and is_load=0 is still granted and completes with rdata=0, rsp_exc=0.
- ACCESS (exactly 1 cycle):
  - mem_* driven from the latched fields; mem_we and mem_is_load equal the latched we and is_load.
  - The memory write occurs at the end of this cycle; the memory itself suppresses the write on exception.
  - On the edge: capture mem_rdata, mem_exc_en, mem_exc_code and mem_exc_val into the rsp_* registers; go to RESP.
- RESP:
  - Owner's rvalid=1; rsp_* stable until rready.
  - The non-owner's rvalid stays 0 and its gnt is never asserted.
  - When owner rready=1 at an edge: rvalid drops the next cycle; go to IDLE.
- mem_we=0 and mem_is_load=0 in IDLE and RESP. mem_addr, mem_word_sel, mem_func3 and mem_wdata hold their last latched values.
- Latency: grant in cycle 0 → access in cycle 1 → rvalid in cycle 2. Minimum of 3 cycles per transaction; back-to-back grant is possible in the cycle after the rready handshake.
- Stores return rvalid with rdata=0, or with an exception.
- A requester must hold req and its fields stable until gnt. Requests that are not granted are not queued.
- Reset mid-operation: state returns to IDLE, mem_we drops immediately, rvalid clears, and any latched transaction is discarded. No write occurs after the reset edge.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, ACCESS=1, RESP=2);
  - word_sel constants SEL_B=0x01, SEL_H=0x03, SEL_W=0x0F, SEL_D=0xFF;
  - exception codes LD_MISALIGN=4, LD_FAULT=5, ST_MISALIGN=6, ST_FAULT=7;
  - DMEM_BASE=0x8000_0000.
- One natural sub-module, dmem_rr_picker: combinational 2-way winner selection plus pointer register, with a PRIO_MODE parameter.

Test Plan:
- p0 store SD, addr 0x8000_0010, wdata 0x1122334455667788; then p0 LD from the same address → gnt at cycle 0, rvalid at cycle 2, rdata=0x1122334455667788, rsp_exc=0.
- p0 and p1 both request LW at 0x8000_0000, PRIO_MODE=0, held continuously with rready=1 → grants alternate p0, p1, p0, p1; each port receives exactly its own rvalid.
- Same stimulus with PRIO_MODE=1 → p0 granted every transaction; p1 is granted only after p0 deasserts req.
- p1 LW at 0x8000_0002 → rsp_exc=1, code=4, val=0x8000_0002. p1 SW at 0x7FFF_FFF0 → code=7, and memory contents are unchanged.
- p0 LB, func3=0, byte 0x80 → rdata=0xFFFF_FFFF_FFFF_FF80. With rready held 0 for 5 cycles, rvalid and rsp_* stay stable and p1_req is not granted.
- Assert rst low during ACCESS of a p0 SD → mem_we=0 immediately, busy=0, rvalid=0; a subsequent LD of that address returns the old value.
